// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: packs an A-then-B element byte stream into flat operand buses and holds them for the multiplier
module matrix_stream_loader #(
   parameter int aRow       = 5,
   parameter int aCol       = 5,
   parameter int bRow       = 5,
   parameter int bCol       = 5,
   parameter int matrixALen = aRow*aCol*8,
   parameter int matrixBLen = bRow*bCol*8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [matrixALen-1:0] a,
   output logic [matrixBLen-1:0] b,
   output logic                  mat_valid,
   input  logic                  mat_ack,
   output logic                  err
);
   localparam int A_N   = aRow*aCol;
   localparam int B_N   = bRow*bCol;
   localparam int MAX_N = A_N > B_N ? A_N : B_N;
   localparam int IW    = MAX_N > 1 ? $clog2(MAX_N) : 1;
   localparam logic [IW-1:0] A_LAST = IW'(A_N-1);
   localparam logic [IW-1:0] B_LAST = IW'(B_N-1);

   if (aCol != bRow) begin : g_dim_check
      $error("matrix_stream_loader: aCol must equal bRow");
   end

   typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD, ERR} state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [matrixALen-1:0] a_q, a_d;
   logic [matrixBLen-1:0] b_q, b_d;
   logic                  rdy_q, rdy_d;
   logic                  xfer;

   assign xfer      = in_valid && rdy_q;
   assign in_ready  = rdy_q;
   assign a         = a_q;
   assign b         = b_q;
   assign mat_valid = state_q == HOLD;
   assign err       = state_q == ERR;

   // Element k sits at the MSB end shifted down by k bytes, so a right shift places each new byte.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      case (state_q)
         LOAD_A: if (xfer) begin
            a_d   = (a_q & ~({8'hFF, {(matrixALen-8){1'b0}}} >> (8*idx_q)))
                  | ({in_data, {(matrixALen-8){1'b0}}} >> (8*idx_q));
            idx_d = idx_q == A_LAST ? '0 : idx_q + 1'b1;
            state_d = in_last ? ERR : idx_q == A_LAST ? LOAD_B : LOAD_A;
         end
         LOAD_B: if (xfer) begin
            b_d   = (b_q & ~({8'hFF, {(matrixBLen-8){1'b0}}} >> (8*idx_q)))
                  | ({in_data, {(matrixBLen-8){1'b0}}} >> (8*idx_q));
            idx_d = idx_q == B_LAST ? '0 : idx_q + 1'b1;
            state_d = idx_q == B_LAST ? (in_last ? HOLD : ERR) : (in_last ? ERR : LOAD_B);
         end
         HOLD: if (mat_ack) begin
            state_d = LOAD_A;
            idx_d   = '0;
         end
         default: ;
      endcase
      rdy_d = state_d == LOAD_A || state_d == LOAD_B;
   end

   // Ready is registered so it stays low for the cycle right after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD_A;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rdy_q   <= rdy_d;
      end
   end
endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb_matrix_stream_loader: directed checks of the default 5x5 loader and a 2x3 by 3x4 instance
module tb_matrix_stream_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic [7:0]   in_data = '0;
   logic         in_valid = 1'b0, in_last = 1'b0, mat_ack = 1'b0;
   logic         in_ready, mat_valid, err;
   logic [199:0] a, b;

   logic [7:0]   in_data2 = '0;
   logic         in_valid2 = 1'b0, in_last2 = 1'b0, mat_ack2 = 1'b0;
   logic         in_ready2, mat_valid2, err2;
   logic [47:0]  a2;
   logic [95:0]  b2;

   int tests = 0;
   int fails = 0;
   logic [199:0] exp_a, exp_b;

   matrix_stream_loader dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .a(a), .b(b), .mat_valid(mat_valid), .mat_ack(mat_ack), .err(err)
   );

   matrix_stream_loader #(.aRow(2), .aCol(3), .bRow(3), .bCol(4)) dut2 (
      .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_last(in_last2),
      .in_ready(in_ready2), .a(a2), .b(b2), .mat_valid(mat_valid2), .mat_ack(mat_ack2), .err(err2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic last, input bit gaps);
      int n;
      if (gaps && $urandom_range(0, 1) == 1) begin
         in_valid = 1'b0;
         step();
      end
      in_data = d; in_last = last; in_valid = 1'b1; n = 0;
      while (!in_ready && n < 100) begin step(); n++; end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL send_timeout in_ready=%b required=1", in_ready);
      end
      step();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send2(input logic [7:0] d, input logic last);
      int n;
      in_data2 = d; in_last2 = last; in_valid2 = 1'b1; n = 0;
      while (!in_ready2 && n < 100) begin step(); n++; end
      if (!in_ready2) begin
         tests++; fails++;
         $display("FAIL send2_timeout in_ready2=%b required=1", in_ready2);
      end
      step();
      in_valid2 = 1'b0; in_last2 = 1'b0;
   endtask

   task automatic pattern_exp();
      for (int k = 0; k < 25; k++) begin
         exp_a[8*(24-k) +: 8] = 8'((k % 5) + 1);
         exp_b[8*(24-k) +: 8] = 8'((k % 5) + 1);
      end
   endtask

   task automatic pattern_frame(input bit gaps);
      for (int k = 0; k < 49; k++) send(8'((k % 5) + 1), 1'b0, gaps);
      tests++;
      if (mat_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL pre_last mat_valid=%b in_ready=%b required 0,1", mat_valid, in_ready);
      end
      send(8'd5, 1'b1, gaps);
   endtask

   task automatic ack();
      mat_ack = 1'b1;
      step();
      mat_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      tests++;
      if (in_ready !== 1'b0 || mat_valid !== 1'b0 || err !== 1'b0 || a !== '0 || b !== '0) begin
         fails++;
         $display("FAIL reset_state in_ready=%b mat_valid=%b err=%b a=%h b=%h required all 0",
                  in_ready, mat_valid, err, a, b);
      end
      rst = 1'b0;
      step();
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready in_ready=%b required=1", in_ready);
      end
   endtask

   task automatic test_full_frame();
      pattern_exp();
      pattern_frame(1'b0);
      tests++;
      if (mat_valid !== 1'b1 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL frame_valid mat_valid=%b in_ready=%b required 1,0", mat_valid, in_ready);
      end
      tests++;
      if (a !== exp_a || b !== exp_b) begin
         fails++;
         $display("FAIL frame_data a=%h b=%h required a=%h b=%h", a, b, exp_a, exp_b);
      end
   endtask

   task automatic test_hold();
      bit bad = 1'b0;
      in_valid = 1'b1; in_data = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         step();
         if (in_ready !== 1'b0 || mat_valid !== 1'b1) bad = 1'b1;
      end
      in_valid = 1'b0;
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL hold_ready in_ready=%b mat_valid=%b required 0,1", in_ready, mat_valid);
      end
      tests++;
      if (a !== exp_a || b !== exp_b) begin
         fails++;
         $display("FAIL hold_data a=%h b=%h required a=%h b=%h", a, b, exp_a, exp_b);
      end
      ack();
      tests++;
      if (mat_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL ack_release mat_valid=%b in_ready=%b required 0,1", mat_valid, in_ready);
      end
      for (int k = 0; k < 50; k++) send(8'(k), k == 49, 1'b0);
      for (int k = 0; k < 25; k++) begin
         exp_a[8*(24-k) +: 8] = 8'(k);
         exp_b[8*(24-k) +: 8] = 8'(k + 25);
      end
      tests++;
      if (mat_valid !== 1'b1 || a !== exp_a || b !== exp_b) begin
         fails++;
         $display("FAIL second_frame mat_valid=%b a=%h b=%h required 1 a=%h b=%h",
                  mat_valid, a, b, exp_a, exp_b);
      end
      ack();
   endtask

   task automatic test_gaps();
      pattern_exp();
      pattern_frame(1'b1);
      tests++;
      if (mat_valid !== 1'b1 || a !== exp_a || b !== exp_b) begin
         fails++;
         $display("FAIL gap_frame mat_valid=%b a=%h b=%h required 1 a=%h b=%h",
                  mat_valid, a, b, exp_a, exp_b);
      end
      ack();
   endtask

   task automatic test_err_b();
      for (int k = 0; k < 29; k++) send(8'((k % 5) + 1), 1'b0, 1'b0);
      send(8'd5, 1'b1, 1'b0);
      tests++;
      if (err !== 1'b1 || in_ready !== 1'b0 || mat_valid !== 1'b0) begin
         fails++;
         $display("FAIL early_last err=%b in_ready=%b mat_valid=%b required 1,0,0", err, in_ready, mat_valid);
      end
      in_valid = 1'b1; mat_ack = 1'b1;
      step(); step(); step();
      in_valid = 1'b0; mat_ack = 1'b0;
      tests++;
      if (err !== 1'b1 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL err_sticky err=%b in_ready=%b required 1,0", err, in_ready);
      end
      rst = 1'b1;
      step();
      tests++;
      if (err !== 1'b0 || a !== '0 || b !== '0 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL err_reset err=%b in_ready=%b a=%h b=%h required 0,0,0,0", err, in_ready, a, b);
      end
      rst = 1'b0;
      step();
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL err_reset_ready in_ready=%b required=1", in_ready);
      end
   endtask

   task automatic test_err_a();
      send(8'h11, 1'b0, 1'b0);
      send(8'h22, 1'b0, 1'b0);
      send(8'h33, 1'b1, 1'b0);
      tests++;
      if (err !== 1'b1 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL last_in_a err=%b in_ready=%b required 1,0", err, in_ready);
      end
      rst = 1'b1; step(); rst = 1'b0; step();
   endtask

   task automatic test_mid_reset();
      for (int k = 0; k < 20; k++) send(8'hAA, 1'b0, 1'b0);
      rst = 1'b1; step(); rst = 1'b0; step();
      pattern_exp();
      pattern_frame(1'b0);
      tests++;
      if (mat_valid !== 1'b1 || a !== exp_a || b !== exp_b) begin
         fails++;
         $display("FAIL mid_reset_frame mat_valid=%b a=%h b=%h required 1 a=%h b=%h",
                  mat_valid, a, b, exp_a, exp_b);
      end
      ack();
   endtask

   task automatic test_nonsquare();
      rst = 1'b1; step(); rst = 1'b0; step();
      for (int k = 0; k < 6; k++) send2(8'(k + 1), 1'b0);
      for (int k = 0; k < 12; k++) send2(8'(k + 1), k == 11);
      tests++;
      if (mat_valid2 !== 1'b1 || a2 !== 48'h010203040506 || b2 !== 96'h0102030405060708090a0b0c) begin
         fails++;
         $display("FAIL nonsquare_frame mat_valid=%b a=%h b=%h required 1 a=010203040506 b=0102030405060708090a0b0c",
                  mat_valid2, a2, b2);
      end
      mat_ack2 = 1'b1; step(); mat_ack2 = 1'b0;
      tests++;
      if (mat_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
         fails++;
         $display("FAIL nonsquare_ack mat_valid=%b in_ready=%b required 0,1", mat_valid2, in_ready2);
      end
      for (int k = 0; k < 18; k++) send2(8'(k), 1'b0);
      tests++;
      if (err2 !== 1'b1 || in_ready2 !== 1'b0 || mat_valid2 !== 1'b0) begin
         fails++;
         $display("FAIL nonsquare_missing_last err=%b in_ready=%b mat_valid=%b required 1,0,0",
                  err2, in_ready2, mat_valid2);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_hold();
      test_gaps();
      test_err_b();
      test_err_a();
      test_mid_reset();
      test_nonsquare();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
